spm_mem_arbiter: RTL and testbench
==================================

# spm_mem_arbiter

Shares the single-port RISC-SPM memory between the processor (instruction fetch, RD/WR/BR/LDR operand and data accesses) and an external loader/debug port. It sits between the control unit/datapath memory signals and the memory array. A registered 4-state FSM grants exactly one owner per cycle and inserts one turnaround cycle on every ownership change. The processor is frozen through `cpu_stall` while it lacks the bus.

## Interface
- `word_size`, 8, memory data width
- `addr_size`, 8, memory address width
- `STARVE_MAX`, 4, cycles a pending requester waits before forced handoff (`ARB_STARVE_EN` only); legal range 1..15
- `clk`  in  1  clock
- `rst`  in  1  reset: asynchronous, active-low
- `cpu_req`  in  1  processor requests memory this cycle
- `cpu_we`  in  1  processor write (WR in S_wr2)
- `cpu_addr`  in  addr_size  processor address (Add_R)
- `cpu_wdata`  in  word_size  processor write data (Bus_1)
- `cpu_gnt`  out  1  processor owns memory (registered)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; control unit holds state and all loads
- `ext_req`  in  1  external port requests memory; held high for a burst
- `ext_we`, `ext_addr`, `ext_wdata`  in  1/addr_size/word_size  external access
- `ext_gnt`  out  1  external port owns memory (registered)
- `rdata`  out  word_size  `mem_rdata` passthrough; valid only to the current owner
- `mem_addr`, `mem_wdata`, `mem_we`  out  addr_size/word_size/1  to memory array
- `mem_rdata`  in  word_size  combinational read data from memory

## Operation
- States: IDLE, CPU, TURN, EXT. `state` register and counter are cleared by async reset.
- IDLE: if `cpu_req`, go to CPU. Else if `ext_req`, go to EXT. Else stay. CPU wins a simultaneous request.
- CPU: `cpu_gnt`=1.
  - If `cpu_req`=0 and `ext_req`=1, go to TURN.
  - If `cpu_req`=0 and `ext_req`=0, go to IDLE.
  - If a forced handoff fires, go to TURN.
  - Otherwise stay.
- EXT: `ext_gnt`=1. Symmetric to CPU: release, or forced handoff when `cpu_req` is pending, goes to TURN.
- TURN: no grant, `mem_we`=0, lasts exactly one cycle, then goes to the requester that did not just own the bus.
  - If that requester has since dropped, serve the other one if it still requests; else go to IDLE.
- Mux: in CPU, `mem_*` take the `cpu_*` values. In EXT, they take the `ext_*` values. In IDLE/TURN, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
- `mem_we` = owner's `we` gated by that owner's grant, so a write can never occur without a grant.
- Starve counter: 4 bits.
  - Increments each cycle the owner holds the bus while the other side requests.
  - Clears on every state change and whenever the other side is not requesting.
  - Saturates at 15.
- Reset mid-operation: immediate IDLE, both grants 0, `mem_we` 0. A write in flight is dropped, not completed.
- Reset values: `cpu_gnt`=0, `ext_gnt`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=`mem_rdata`, `cpu_stall`=`cpu_req`.

## Timing
- Requests are sampled at posedge. The grant registers assert at the following posedge, giving 1-cycle grant latency from IDLE.
- An access completes in the cycle its grant is high. The requester must hold `addr`/`we`/`wdata` stable from request until it sees the grant.
- Read data is combinational from `mem_rdata` in the granted cycle. Writes commit at the posedge closing the granted cycle.
- Ownership change costs exactly 1 TURN cycle. The first new grant appears 2 cycles after the old owner's release is sampled.
- Forced handoff: the owner keeps the grant for `STARVE_MAX` cycles after the other side is first seen requesting. TURN follows, then the waiter gets the grant.

## Configuration
- `ARB_STARVE_EN` defined:
  - The starve counter and forced handoff are built, in both directions.
  - No requester waits more than `STARVE_MAX`+2 cycles.
- `ARB_STARVE_EN` undefined:
  - No counter is built.
  - Strict CPU priority: EXT is entered only while `cpu_req`=0.
  - EXT is left only when `ext_req` drops. A pending `cpu_req` does not preempt EXT; the CPU stalls until `ext_req` drops.

## Test plan
- Reset with `cpu_req`=1, release at cycle 0: `cpu_gnt`=1 at cycle 1 and `cpu_stall`=0; `mem_addr` follows `cpu_addr`=8'h3C.
- `cpu_req` and `ext_req` rise in the same IDLE cycle: CPU is granted; `ext_gnt` stays 0 while CPU holds.
- With the macro defined and `STARVE_MAX`=4, CPU holds and `ext_req` is held high: the forced handoff occurs and the external write to 8'hF0 lands with `mem_we`=1 for exactly one cycle per granted cycle.
- Without the macro, ext holds a 6-cycle burst while `cpu_req`=1: `cpu_stall`=1 throughout; CPU is granted 2 cycles after `ext_req` drops.
- `rst` asserted while EXT is writing: same cycle `ext_gnt`=0 and `mem_we`=0; the memory location stays unchanged.
- CPU release while `ext_req`=0: return to IDLE with all `mem_*` at 0.

Source files
------------

// File: rtl/spm_mem_arbiter.sv
// spm_mem_arbiter
//   Shares the single-port RISC-SPM memory between the processor and an
//   external loader/debug port. A registered 4-state FSM (IDLE, CPU, TURN, EXT)
//   grants exactly one owner per cycle. Every ownership change passes through
//   one TURN cycle in which nobody owns the memory and no write can happen.
//
// Optional feature (macro ARB_STARVE_EN):
//   defined   -> 4-bit starve counter; the owner is forced off the bus after
//                holding it STARVE_MAX cycles while the other side waits.
//   undefined -> strict CPU priority; an external burst is never preempted.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata         processor access request
//   cpu_gnt, cpu_stall            processor grant (registered) and freeze
//   ext_req/we/addr/wdata         external port access request
//   ext_gnt                       external grant (registered)
//   rdata                         mem_rdata passthrough for the current owner
//   mem_addr/wdata/we             to the memory array
//   mem_rdata                     combinational read data from the array
module spm_mem_arbiter #(
  parameter int word_size  = 8,
  parameter int addr_size  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [addr_size-1:0] cpu_addr,
  input  logic [word_size-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_stall,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [addr_size-1:0] ext_addr,
  input  logic [word_size-1:0] ext_wdata,
  output logic                 ext_gnt,
  output logic [word_size-1:0] rdata,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [word_size-1:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("spm_mem_arbiter: STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_TURN, S_EXT} state_e;

  state_e state_q, state_d;
  logic   cpu_gnt_q, cpu_gnt_d;
  logic   ext_gnt_q, ext_gnt_d;

`ifdef ARB_STARVE_EN
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  logic [3:0] starve_q, starve_d;
  // Remembers who owned the bus before TURN so the waiter is served next.
  logic       last_ext_q, last_ext_d;
  logic       other_req;
  logic       force_handoff;

  // The requester that is not the current owner; meaningless in IDLE/TURN.
  assign other_req     = (state_q == S_CPU) ? ext_req : cpu_req;
  // The current cycle is the STARVE_MAX-th one the waiter has been pending.
  assign force_handoff = other_req && (starve_q >= STARVE_LAST);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req)      state_d = S_CPU;
        else if (ext_req) state_d = S_EXT;
      end
      S_CPU: begin
        if (!cpu_req)          state_d = ext_req ? S_TURN : S_IDLE;
`ifdef ARB_STARVE_EN
        else if (force_handoff) state_d = S_TURN;
`endif
      end
      S_EXT: begin
        if (!ext_req)          state_d = cpu_req ? S_TURN : S_IDLE;
`ifdef ARB_STARVE_EN
        else if (force_handoff) state_d = S_TURN;
`endif
      end
      S_TURN: begin
`ifdef ARB_STARVE_EN
        if (last_ext_q) state_d = cpu_req ? S_CPU : (ext_req ? S_EXT : S_IDLE);
        else            state_d = ext_req ? S_EXT : (cpu_req ? S_CPU : S_IDLE);
`else
        // Strict priority: EXT is only ever entered while the CPU is quiet.
        state_d = cpu_req ? S_CPU : (ext_req ? S_EXT : S_IDLE);
`endif
      end
      default: state_d = S_IDLE;
    endcase

    cpu_gnt_d = (state_d == S_CPU);
    ext_gnt_d = (state_d == S_EXT);
  end

`ifdef ARB_STARVE_EN
  always_comb begin
    starve_d   = starve_q;
    last_ext_d = last_ext_q;
    if (state_q == S_CPU) last_ext_d = 1'b0;
    if (state_q == S_EXT) last_ext_d = 1'b1;

    // Only an owner with a waiting peer accumulates; any state change restarts.
    if ((state_d != state_q) || !other_req ||
        (state_q == S_IDLE) || (state_q == S_TURN)) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cpu_gnt_q  <= 1'b0;
      ext_gnt_q  <= 1'b0;
`ifdef ARB_STARVE_EN
      starve_q   <= 4'd0;
      last_ext_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cpu_gnt_q  <= cpu_gnt_d;
      ext_gnt_q  <= ext_gnt_d;
`ifdef ARB_STARVE_EN
      starve_q   <= starve_d;
      last_ext_q <= last_ext_d;
`endif
    end
  end

  // Memory mux is steered by the grant flops, so a write without a grant is
  // impossible and reset kills an in-flight write immediately.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt_q) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (ext_gnt_q) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_we    = ext_we;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign ext_gnt   = ext_gnt_q;
  assign cpu_stall = cpu_req & ~cpu_gnt_q;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_spm_mem_arbiter.sv
// tb_spm_mem_arbiter
//   Bench for spm_mem_arbiter: directed scenarios with constant expectations
//   followed by a randomized request phase checked against an owner-level
//   reference model. The bench also provides the memory array.
//   Build with +define+ARB_STARVE_EN to exercise the forced handoff.
module tb_spm_mem_arbiter;

  localparam int SMAX = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic       cpu_gnt, cpu_stall, ext_gnt, mem_we;
  logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  spm_mem_arbiter #(.word_size(8), .addr_size(8), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array driven by the DUT's memory port.
  logic [7:0] mem [256];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model: who owns the bus, whether we are in the gap between
  // owners, who owned last, and how long the current owner has made the
  // other side wait.
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_e;
  typedef struct {
    owner_e owner;
    owner_e last;
    bit     turn;
    int     wait_cnt;
  } mstate_t;

  mstate_t m_s;
  logic [7:0] m_mem [256];

  function automatic mstate_t model_next(mstate_t s, bit creq, bit ereq);
    mstate_t n = s;
    bit own_req, oth_req;
    if (s.turn) begin
      n.turn = 1'b0;
      n.wait_cnt = 0;
`ifdef ARB_STARVE_EN
      if (s.last == OWN_CPU) n.owner = ereq ? OWN_EXT : (creq ? OWN_CPU : OWN_NONE);
      else                   n.owner = creq ? OWN_CPU : (ereq ? OWN_EXT : OWN_NONE);
`else
      n.owner = creq ? OWN_CPU : (ereq ? OWN_EXT : OWN_NONE);
`endif
    end else if (s.owner == OWN_NONE) begin
      n.owner = creq ? OWN_CPU : (ereq ? OWN_EXT : OWN_NONE);
      n.wait_cnt = 0;
    end else begin
      own_req = (s.owner == OWN_CPU) ? creq : ereq;
      oth_req = (s.owner == OWN_CPU) ? ereq : creq;
      if (!own_req) begin
        n.last = s.owner; n.owner = OWN_NONE; n.turn = oth_req; n.wait_cnt = 0;
`ifdef ARB_STARVE_EN
      end else if (oth_req && (s.wait_cnt + 1 >= SMAX)) begin
        n.last = s.owner; n.owner = OWN_NONE; n.turn = 1'b1; n.wait_cnt = 0;
`endif
      end else begin
        n.wait_cnt = oth_req ? ((s.wait_cnt < 15) ? s.wait_cnt + 1 : 15) : 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_s <= '{OWN_NONE, OWN_NONE, 1'b0, 0};
    else      m_s <= model_next(m_s, cpu_req, ext_req);
  end

  logic       exp_cpu_gnt, exp_ext_gnt, exp_we, exp_stall;
  logic [7:0] exp_addr, exp_wdata, exp_rdata;

  always_comb begin
    exp_cpu_gnt = (m_s.owner == OWN_CPU);
    exp_ext_gnt = (m_s.owner == OWN_EXT);
    exp_we      = 1'b0;
    exp_addr    = 8'h00;
    exp_wdata   = 8'h00;
    if (exp_cpu_gnt) begin
      exp_we = cpu_we; exp_addr = cpu_addr; exp_wdata = cpu_wdata;
    end else if (exp_ext_gnt) begin
      exp_we = ext_we; exp_addr = ext_addr; exp_wdata = ext_wdata;
    end
    exp_stall = cpu_req & ~exp_cpu_gnt;
    exp_rdata = m_mem[exp_addr];
  end

  always @(posedge clk) if (exp_we) m_mem[exp_addr] <= exp_wdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    cpu_req = 1'b0; ext_req = 1'b0; cpu_we = 1'b0; ext_we = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h3C; cpu_wdata = 8'h00;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'h00; ext_wdata = 8'h00;
    #2 rst = 1'b0;
    #3;
    n_vec++;
    if ({cpu_gnt, ext_gnt, mem_we, cpu_stall} !== 4'b0001) begin
      n_bad++; $display("[TB] FAIL reset_flags: got %b expected 0001", {cpu_gnt, ext_gnt, mem_we, cpu_stall});
    end
    n_vec++;
    if ({mem_addr, mem_wdata} !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL reset_bus: got %h expected 0000", {mem_addr, mem_wdata});
    end
    n_vec++;
    if (rdata !== 8'h5A) begin
      n_bad++; $display("[TB] FAIL reset_rdata: got %h expected 5a", rdata);
    end
    @(negedge clk) rst = 1'b1;
    step();
    v = {cpu_gnt, ext_gnt, cpu_stall, 5'b0};
    n_vec++;
    if (v !== 8'h80) begin
      n_bad++; $display("[TB] FAIL first_grant: got %h expected 80", v);
    end
    n_vec++;
    if ({mem_addr, rdata} !== 16'h3C66) begin
      n_bad++; $display("[TB] FAIL first_grant_bus: got %h expected 3c66", {mem_addr, rdata});
    end
  endtask

  task automatic test_cpu_release();
    cpu_req = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'h99;
    step();
    n_vec++;
    if ({cpu_gnt, ext_gnt, mem_we, mem_addr, mem_wdata} !== 19'h0) begin
      n_bad++; $display("[TB] FAIL release_idle: got %h expected 0",
                        {cpu_gnt, ext_gnt, mem_we, mem_addr, mem_wdata});
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_simultaneous();
    cpu_req = 1'b1; cpu_addr = 8'h11; ext_req = 1'b1; ext_addr = 8'h22;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({cpu_gnt, ext_gnt, cpu_stall, mem_addr} !== {3'b100, 8'h11}) begin
        n_bad++; $display("[TB] FAIL simultaneous_c%0d: got %h expected 411", i,
                          {cpu_gnt, ext_gnt, cpu_stall, mem_addr});
      end
    end
    go_idle();
  endtask

`ifdef ARB_STARVE_EN
  task automatic test_forced_handoff();
    cpu_req = 1'b1; cpu_addr = 8'h44; cpu_we = 1'b0;
    step();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'hF0; ext_wdata = 8'hA5;
    for (int i = 0; i < SMAX - 1; i++) begin
      step();
      n_vec++;
      if ({cpu_gnt, ext_gnt} !== 2'b10) begin
        n_bad++; $display("[TB] FAIL force_hold_c%0d: got %b expected 10", i, {cpu_gnt, ext_gnt});
      end
    end
    step();
    n_vec++;
    if ({cpu_gnt, ext_gnt, mem_we} !== 3'b000) begin
      n_bad++; $display("[TB] FAIL force_turn: got %b expected 000", {cpu_gnt, ext_gnt, mem_we});
    end
    for (int i = 0; i < SMAX; i++) begin
      step();
      n_vec++;
      if ({ext_gnt, mem_we, cpu_stall, mem_addr} !== {3'b111, 8'hF0}) begin
        n_bad++; $display("[TB] FAIL force_ext_c%0d: got %h expected 7f0", i,
                          {ext_gnt, mem_we, cpu_stall, mem_addr});
      end
    end
    step();
    n_vec++;
    if ({cpu_gnt, ext_gnt, mem_we} !== 3'b000) begin
      n_bad++; $display("[TB] FAIL force_turn_back: got %b expected 000", {cpu_gnt, ext_gnt, mem_we});
    end
    step();
    n_vec++;
    if ({cpu_gnt, cpu_stall} !== 2'b10) begin
      n_bad++; $display("[TB] FAIL force_cpu_back: got %b expected 10", {cpu_gnt, cpu_stall});
    end
    go_idle();
    n_vec++;
    if (mem[8'hF0] !== 8'hA5) begin
      n_bad++; $display("[TB] FAIL force_write: got %h expected a5", mem[8'hF0]);
    end
  endtask
`else
  task automatic test_ext_burst();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'hF0; ext_wdata = 8'h3C;
    step();
    cpu_req = 1'b1; cpu_addr = 8'h44;
    #1;
    n_vec++;
    if ({ext_gnt, mem_we, cpu_stall, mem_addr} !== {3'b111, 8'hF0}) begin
      n_bad++; $display("[TB] FAIL burst_start: got %h expected 7f0", {ext_gnt, mem_we, cpu_stall, mem_addr});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b011) begin
        n_bad++; $display("[TB] FAIL burst_c%0d: got %b expected 011", i, {cpu_gnt, ext_gnt, cpu_stall});
      end
    end
    ext_req = 1'b0;
    step();
    n_vec++;
    if ({cpu_gnt, ext_gnt, mem_we, cpu_stall} !== 4'b0001) begin
      n_bad++; $display("[TB] FAIL burst_turn: got %b expected 0001", {cpu_gnt, ext_gnt, mem_we, cpu_stall});
    end
    step();
    n_vec++;
    if ({cpu_gnt, cpu_stall, mem_addr} !== {2'b10, 8'h44}) begin
      n_bad++; $display("[TB] FAIL burst_cpu_gnt: got %h expected 244", {cpu_gnt, cpu_stall, mem_addr});
    end
    go_idle();
    n_vec++;
    if (mem[8'hF0] !== 8'h3C) begin
      n_bad++; $display("[TB] FAIL burst_write: got %h expected 3c", mem[8'hF0]);
    end
  endtask
`endif

  task automatic test_reset_mid_write();
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h55; ext_wdata = 8'hC3;
    step();
    n_vec++;
    if ({ext_gnt, mem_we} !== 2'b11) begin
      n_bad++; $display("[TB] FAIL midwrite_gnt: got %b expected 11", {ext_gnt, mem_we});
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({cpu_gnt, ext_gnt, mem_we, mem_addr} !== 11'h0) begin
      n_bad++; $display("[TB] FAIL midwrite_reset: got %h expected 0", {cpu_gnt, ext_gnt, mem_we, mem_addr});
    end
    step();
    n_vec++;
    if (mem[8'h55] !== 8'h0F) begin
      n_bad++; $display("[TB] FAIL midwrite_mem: got %h expected 0f", mem[8'h55]);
    end
    ext_req = 1'b0; ext_we = 1'b0;
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [27:0] got, exp;
    int bad_cells;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(0, 4) == 0) ext_req = ~ext_req;
      cpu_we = 1'($urandom_range(0, 1)); ext_we = 1'($urandom_range(0, 1));
      cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      ext_addr = 8'($urandom); ext_wdata = 8'($urandom);
      step();
      got = {cpu_gnt, ext_gnt, mem_we, cpu_stall, mem_addr, mem_wdata, rdata};
      exp = {exp_cpu_gnt, exp_ext_gnt, exp_we, exp_stall, exp_addr, exp_wdata, exp_rdata};
      n_vec++;
      if (got !== exp) begin
        n_bad++; $display("[TB] FAIL random_c%0d: got %h expected %h", i, got, exp);
      end
    end
    go_idle();
    bad_cells = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== m_mem[a]) bad_cells++;
    n_vec++;
    if (bad_cells != 0) begin
      n_bad++; $display("[TB] FAIL memory_image: got %0d differing cells expected 0", bad_cells);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]   <= 8'(a) ^ 8'h5A;
      m_mem[a] <= 8'(a) ^ 8'h5A;
    end
    test_reset();
    test_cpu_release();
    test_simultaneous();
`ifdef ARB_STARVE_EN
    test_forced_handoff();
`else
    test_ext_burst();
`endif
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
